// File: rtl/hex_scan_controller.sv
// Shares one external 7-segment decoder across HEX0..HEX5 by scanning the
// digit registers round-robin and latching each decoded result into its display.
module hex_scan_controller #(
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W    = 16
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       wr_valid,
  input  logic [2:0] wr_idx,
  input  logic [3:0] wr_data,
  output logic       wr_ready,
  input  logic [5:0] blank,
  output logic [3:0] dec_nibble,
  input  logic [6:0] dec_seg,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic       refresh_done,
  output logic       bad_idx
);

  typedef enum logic [1:0] {
    S_WAIT    = 2'd0,
    S_DRIVE   = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [6:0]       SEG_DARK = 7'h7F;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [3:0]       digit_q [6];
  logic [3:0]       digit_d [6];
  logic [6:0]       hex_q [6];
  logic [6:0]       hex_d [6];
  logic [3:0]       dec_nibble_q, dec_nibble_d;
  logic             refresh_done_q, refresh_done_d;
  logic             bad_idx_q, bad_idx_d;
  logic             wr_ready_q, wr_ready_d;
  logic             wr_fire;
  logic [3:0]       cur_digit;

  assign wr_fire = wr_valid & wr_ready_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    dec_nibble_d   = dec_nibble_q;
    refresh_done_d = 1'b0;
    bad_idx_d      = bad_idx_q;
    wr_ready_d     = 1'b1;
    cur_digit      = 4'd0;
    for (int i = 0; i < 6; i++) begin
      digit_d[i] = digit_q[i];
      hex_d[i]   = hex_q[i];
    end

    // The scan reads the registered digit, so a same-cycle write lands next round.
    for (int i = 0; i < 6; i++) begin
      if (idx_q == 3'(i)) cur_digit = digit_q[i];
    end

    if (wr_fire) begin
      if (wr_idx <= 3'd5) begin
        for (int i = 0; i < 6; i++) begin
          if (wr_idx == 3'(i)) digit_d[i] = wr_data;
        end
      end else begin
        bad_idx_d = 1'b1;
      end
    end

    case (state_q)
      S_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d        = '0;
          dec_nibble_d = cur_digit;
          state_d      = S_DRIVE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DRIVE: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        for (int i = 0; i < 6; i++) begin
          if (idx_q == 3'(i)) hex_d[i] = blank[i] ? SEG_DARK : dec_seg;
        end
        idx_d          = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        refresh_done_d = (idx_q == 3'd5);
        state_d        = S_WAIT;
      end
      default: begin
        state_d = S_WAIT;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q        <= S_WAIT;
      cnt_q          <= '0;
      idx_q          <= 3'd0;
      dec_nibble_q   <= 4'd0;
      refresh_done_q <= 1'b0;
      bad_idx_q      <= 1'b0;
      wr_ready_q     <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        digit_q[i] <= 4'd0;
        hex_q[i]   <= SEG_DARK;
      end
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      dec_nibble_q   <= dec_nibble_d;
      refresh_done_q <= refresh_done_d;
      bad_idx_q      <= bad_idx_d;
      wr_ready_q     <= wr_ready_d;
      for (int i = 0; i < 6; i++) begin
        digit_q[i] <= digit_d[i];
        hex_q[i]   <= hex_d[i];
      end
    end
  end

  assign wr_ready     = wr_ready_q;
  assign dec_nibble   = dec_nibble_q;
  assign refresh_done = refresh_done_q;
  assign bad_idx      = bad_idx_q;
  assign HEX0         = hex_q[0];
  assign HEX1         = hex_q[1];
  assign HEX2         = hex_q[2];
  assign HEX3         = hex_q[3];
  assign HEX4         = hex_q[4];
  assign HEX5         = hex_q[5];

endmodule
